// File: rtl/register_file.sv
// LEGv8 architectural register file: 32 x 64-bit, XZR hardwired to zero,
// two combinational operand read ports plus a debug port, one clocked write port.
module register_file #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 31,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                  Clk,
    input  logic                  Resetb,
    input  logic [ADDR_WIDTH-1:0] RA,
    input  logic [ADDR_WIDTH-1:0] RB,
    input  logic [ADDR_WIDTH-1:0] RW,
    input  logic [DATA_WIDTH-1:0] BusW,
    input  logic                  RegWr,
    input  logic [ADDR_WIDTH-1:0] RD,
    output logic [DATA_WIDTH-1:0] BusA,
    output logic [DATA_WIDTH-1:0] BusB,
    output logic [DATA_WIDTH-1:0] BusD,
    output logic [15:0]           WrCount
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ZERO_REG[ADDR_WIDTH-1:0];

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [15:0]           wr_count_q;
    logic [15:0]           wr_count_d;
    logic                  wr_en;

    // A write held while in reset is neither committed nor forwarded.
    assign wr_en = RegWr && Resetb && (RW != ZERO_IDX);

    always_comb begin
        regs_d     = regs_q;
        wr_count_d = wr_count_q;
        if (wr_en) begin
            regs_d[RW] = BusW;
            wr_count_d = wr_count_q + 16'd1;
        end
    end

    always_ff @(posedge Clk or negedge Resetb) begin
        if (!Resetb) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            wr_count_q <= '0;
        end else begin
            regs_q     <= regs_d;
            wr_count_q <= wr_count_d;
        end
    end

    // XZR check comes first so a forwarded write can never leak onto index 31.
    function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] idx);
        logic [DATA_WIDTH-1:0] value;
        if (idx == ZERO_IDX) begin
            value = '0;
        end else if (BYPASS && wr_en && (idx == RW)) begin
            value = BusW;
        end else begin
            value = regs_q[idx];
        end
        return value;
    endfunction

    always_comb begin
        BusA = read_port(RA);
        BusB = read_port(RB);
        BusD = read_port(RD);
    end

    assign WrCount = wr_count_q;

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed vector table, hand-written
// reset/XZR/wrap sequences and a randomized phase against an array-based model.
module tb_register_file;

    logic        Clk = 1'b0;
    logic        Resetb;
    logic [4:0]  RA, RB, RW, RD;
    logic [63:0] BusW;
    logic        RegWr;

    logic [63:0] busA, busB, busD;
    logic [15:0] wrCount;
    logic [63:0] nbBusA, nbBusB, nbBusD;
    logic [15:0] nbWrCount;

    int errors;
    int checks;

    // Behavioural reference: plain array of register values and a write counter.
    logic [63:0] modelRegs [32];
    logic [15:0] modelCnt;

    typedef struct {
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [4:0]  rw;
        logic [4:0]  rd;
        logic        regwr;
        logic [63:0] busw;
        logic [63:0] expA;
        logic [63:0] expB;
        logic [63:0] expD;
        logic [63:0] expANb;
        logic [15:0] expCnt;
    } vec_t;

    vec_t vecs [10];

    always #5 Clk = ~Clk;

    register_file #(.BYPASS(1'b1)) dut (
        .Clk(Clk), .Resetb(Resetb), .RA(RA), .RB(RB), .RW(RW), .BusW(BusW),
        .RegWr(RegWr), .RD(RD), .BusA(busA), .BusB(busB), .BusD(busD), .WrCount(wrCount)
    );

    register_file #(.BYPASS(1'b0)) dutNb (
        .Clk(Clk), .Resetb(Resetb), .RA(RA), .RB(RB), .RW(RW), .BusW(BusW),
        .RegWr(RegWr), .RD(RD), .BusA(nbBusA), .BusB(nbBusB), .BusD(nbBusD), .WrCount(nbWrCount)
    );

    task automatic applyStimulus(input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rw,
                                 input logic [4:0] rd, input logic regwr, input logic [63:0] busw);
        RA = ra; RB = rb; RW = rw; RD = rd; RegWr = regwr; BusW = busw;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic clearModel();
        for (int i = 0; i < 32; i++) modelRegs[i] = '0;
        modelCnt = '0;
    endtask

    // Advance one clock edge and commit the held write into the model.
    task automatic tick();
        @(posedge Clk);
        #1;
        if (Resetb && RegWr && RW != 5'd31) begin
            modelRegs[RW] = BusW;
            modelCnt = modelCnt + 16'd1;
        end
    endtask

    function automatic logic [63:0] expRead(input logic [4:0] idx, input bit bypass);
        if (idx == 5'd31) return 64'd0;
        if (bypass && Resetb && RegWr && RW != 5'd31 && RW == idx) return BusW;
        return modelRegs[idx];
    endfunction

    initial begin
        errors = 0;
        checks = 0;
        clearModel();

        //            ra  rb  rw  rd  we  busw                    expA                    expB                    expD                    expANb                  cnt
        vecs[0] = '{5'd5,  5'd31, 5'd5,  5'd0,  1'b1, 64'h1234,               64'h1234,               64'h0,                  64'h0,                  64'h0,                  16'd1};
        vecs[1] = '{5'd5,  5'd5,  5'd0,  5'd5,  1'b0, 64'h0,                  64'h1234,               64'h1234,               64'h1234,               64'h1234,               16'd1};
        vecs[2] = '{5'd1,  5'd2,  5'd1,  5'd31, 1'b1, 64'h1234,               64'h1234,               64'h0,                  64'h0,                  64'h0,                  16'd2};
        vecs[3] = '{5'd1,  5'd2,  5'd2,  5'd2,  1'b1, 64'hABCD0000,           64'h1234,               64'hABCD0000,           64'hABCD0000,           64'h1234,               16'd3};
        vecs[4] = '{5'd31, 5'd1,  5'd31, 5'd31, 1'b1, 64'hFFFFFFFFFFFFFFFF,   64'h0,                  64'h1234,               64'h0,                  64'h0,                  16'd3};
        vecs[5] = '{5'd31, 5'd2,  5'd0,  5'd1,  1'b0, 64'h0,                  64'h0,                  64'hABCD0000,           64'h1234,               64'h0,                  16'd3};
        vecs[6] = '{5'd4,  5'd4,  5'd3,  5'd3,  1'b1, 64'h1111,               64'h0,                  64'h0,                  64'h1111,               64'h0,                  16'd4};
        vecs[7] = '{5'd3,  5'd3,  5'd3,  5'd3,  1'b1, 64'hAEF4,               64'hAEF4,               64'hAEF4,               64'hAEF4,               64'h1111,               16'd5};
        vecs[8] = '{5'd3,  5'd1,  5'd3,  5'd0,  1'b0, 64'hDEAD,               64'hAEF4,               64'h1234,               64'h0,                  64'hAEF4,               16'd5};
        vecs[9] = '{5'd2,  5'd3,  5'd2,  5'd2,  1'b0, 64'h5555,               64'hABCD0000,           64'hAEF4,               64'hABCD0000,           64'hABCD0000,           16'd5};

        // Reset held with a write pending: nothing may be forwarded or committed.
        Resetb = 1'b0;
        applyStimulus(5'd5, 5'd31, 5'd5, 5'd0, 1'b1, 64'hCAFE);
        repeat (2) @(posedge Clk);
        #1;
        checkOutput("reset_busA", busA, 64'd0);
        checkOutput("reset_busB", busB, 64'd0);
        checkOutput("reset_busD", busD, 64'd0);
        checkOutput("reset_wrcount", {48'd0, wrCount}, 64'd0);
        checkOutput("reset_nb_busA", nbBusA, 64'd0);
        RegWr = 1'b0;
        Resetb = 1'b1;

        // Directed vector table.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].ra, vecs[i].rb, vecs[i].rw, vecs[i].rd, vecs[i].regwr, vecs[i].busw);
            checkOutput($sformatf("vec%0d_busA", i), busA, vecs[i].expA);
            checkOutput($sformatf("vec%0d_busB", i), busB, vecs[i].expB);
            checkOutput($sformatf("vec%0d_busD", i), busD, vecs[i].expD);
            checkOutput($sformatf("vec%0d_nb_busA", i), nbBusA, vecs[i].expANb);
            tick();
            checkOutput($sformatf("vec%0d_wrcount", i), {48'd0, wrCount}, {48'd0, vecs[i].expCnt});
            checkOutput($sformatf("vec%0d_nb_wrcount", i), {48'd0, nbWrCount}, {48'd0, vecs[i].expCnt});
        end

        // Operands X1 and X2 feeding an ADD.
        applyStimulus(5'd1, 5'd2, 5'd0, 5'd0, 1'b0, 64'd0);
        checkOutput("alu_add_sum", busA + busB, 64'hABCD1234);

        // Randomized phase against the model, biased towards bypass and XZR hits.
        for (int n = 0; n < 300; n++) begin
            logic [4:0] ra, rb, rw, rd;
            ra = 5'($urandom_range(0, 31));
            rb = ($urandom_range(0, 3) == 0) ? ra : 5'($urandom_range(0, 31));
            rd = 5'($urandom_range(0, 31));
            case ($urandom_range(0, 4))
                0: rw = ra;
                1: rw = 5'd31;
                default: rw = 5'($urandom_range(0, 31));
            endcase
            applyStimulus(ra, rb, rw, rd, 1'($urandom_range(0, 1)), {$urandom, $urandom});
            checkOutput("rand_busA", busA, expRead(RA, 1'b1));
            checkOutput("rand_busB", busB, expRead(RB, 1'b1));
            checkOutput("rand_busD", busD, expRead(RD, 1'b1));
            checkOutput("rand_nb_busA", nbBusA, expRead(RA, 1'b0));
            checkOutput("rand_nb_busB", nbBusB, expRead(RB, 1'b0));
            checkOutput("rand_nb_busD", nbBusD, expRead(RD, 1'b0));
            tick();
            checkOutput("rand_wrcount", {48'd0, wrCount}, {48'd0, modelCnt});
        end

        // Sweep X0..X30 with a formula value, then read back through all ports.
        for (int i = 0; i < 31; i++) begin
            applyStimulus(5'd0, 5'd0, 5'(i), 5'd0, 1'b1, 64'(i) * 64'h0101010101010101);
            tick();
        end
        RegWr = 1'b0;
        for (int i = 0; i < 31; i++) begin
            applyStimulus(5'(i), 5'((i + 1) % 31), 5'd0, 5'((i + 2) % 31), 1'b0, 64'd0);
            checkOutput($sformatf("sweep_busA_x%0d", i), busA, 64'(i) * 64'h0101010101010101);
            checkOutput($sformatf("sweep_busB_x%0d", (i + 1) % 31), busB, 64'((i + 1) % 31) * 64'h0101010101010101);
            checkOutput($sformatf("sweep_busD_x%0d", (i + 2) % 31), busD, 64'((i + 2) % 31) * 64'h0101010101010101);
        end

        // Reset asserted between edges clears state immediately; an edge during reset writes nothing.
        applyStimulus(5'd0, 5'd0, 5'd7, 5'd7, 1'b1, 64'h0832FAAA);
        tick();
        applyStimulus(5'd0, 5'd0, 5'd7, 5'd7, 1'b0, 64'd0);
        checkOutput("midreset_before_busD", busD, 64'h0832FAAA);
        #2;
        Resetb = 1'b0;
        clearModel();
        #1;
        checkOutput("midreset_busD_now", busD, 64'd0);
        checkOutput("midreset_wrcount_now", {48'd0, wrCount}, 64'd0);
        checkOutput("midreset_nb_busD_now", nbBusD, 64'd0);
        applyStimulus(5'd7, 5'd7, 5'd7, 5'd7, 1'b1, 64'h99);
        checkOutput("midreset_no_bypass", busA, 64'd0);
        tick();
        checkOutput("midreset_edge_busD", busD, 64'd0);
        RegWr = 1'b0;
        Resetb = 1'b1;
        tick();
        checkOutput("midreset_after_busD", busD, 64'd0);
        checkOutput("midreset_after_wrcount", {48'd0, wrCount}, 64'd0);

        // Counter wrap: 65535 writes reach 0xFFFF, one more wraps to zero.
        for (int i = 0; i < 65535; i++) begin
            RW = 5'(i % 31);
            BusW = {$urandom, $urandom};
            RegWr = 1'b1;
            tick();
        end
        checkOutput("wrap_at_ffff", {48'd0, wrCount}, 64'h000000000000FFFF);
        applyStimulus(5'd12, 5'd31, 5'd12, 5'd30, 1'b1, 64'h0123456789ABCDEF);
        tick();
        checkOutput("wrap_to_zero", {48'd0, wrCount}, 64'd0);
        checkOutput("wrap_nb_to_zero", {48'd0, nbWrCount}, 64'd0);
        RegWr = 1'b0;
        #1;
        checkOutput("wrap_final_busA", busA, 64'h0123456789ABCDEF);
        checkOutput("wrap_final_busD", busD, modelRegs[30]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
Architectural register file for the single-cycle LEGv8 datapath; sits directly upstream of the ALU. It supplies BusA/BusB operands and accepts the BusW write-back result. It holds 32 x 64-bit registers with X31 hardwired to zero (XZR). It has two combinational read ports, one clocked write port, optional write-to-read bypass, and a third debug read port for bench inspection.

Parameters:
DATA_WIDTH, 64, register and bus width
ADDR_WIDTH, 5, register index width (2**ADDR_WIDTH registers)
ZERO_REG, 31, index that always reads 0 and ignores writes
BYPASS, 1, 1 = a same-cycle write to a read index is forwarded to that read bus; 0 = reads show the stored value only

Ports:
Clk  input  1  clock; all state updates on rising edge
Resetb  input  1  asynchronous active-low reset
RA  input  ADDR_WIDTH  read port A index
RB  input  ADDR_WIDTH  read port B index
RW  input  ADDR_WIDTH  write index
BusW  input  DATA_WIDTH  write data (ALU/memory write-back)
RegWr  input  1  write enable
RD  input  ADDR_WIDTH  debug read index
BusA  output  DATA_WIDTH  read data A (to ALU BusA)
BusB  output  DATA_WIDTH  read data B (to ALU BusB via operand mux)
BusD  output  DATA_WIDTH  debug read data
WrCount  output  16  count of committed writes since reset

Behaviour:
- Reset: Resetb low asynchronously clears all registers to 0 and WrCount to 0. BusA/BusB/BusD read 0 while reset is held. Release is synchronous to the first Clk rising edge after Resetb goes high; no write is accepted on an edge where Resetb is low.
- Write: on the Clk rising edge with RegWr=1 and RW!=ZERO_REG, reg[RW] <= BusW, and WrCount increments, wrapping 0xFFFF->0x0000.
- RegWr=1 with RW=ZERO_REG: no state change and no WrCount increment.
- RegWr=0: no state change.
- Reads: combinational, zero latency. BusA=reg[RA], BusB=reg[RB], BusD=reg[RD].
- Any read index equal to ZERO_REG returns 0 regardless of stored contents or bypass.
- Bypass (BYPASS=1): when RegWr=1, RW!=ZERO_REG and RA==RW, BusA=BusW in the same cycle. Same rule for BusB and BusD.
- With BYPASS=0, the new value is visible only after the write edge.
- RA==RB==RW: both buses are bypassed identically.
- Write and reset in the same cycle: reset wins; the register stays 0.
- Reset asserted mid-program: all state is lost immediately, not at the next edge.
- X/undefined indices are not defined behaviour. The bench must drive known values.

Test Plan:
- Reset: Resetb=0, then RA=5, RB=31, RD=0 -> BusA=BusB=BusD=0 and WrCount=0. Release, then write X5=0x1234, RegWr=1 -> after the edge, BusA=0x1234 and WrCount=1.
- ALU feed: write X1=0x1234 and X2=0xABCD0000, then RA=1, RB=2 -> BusA=0x1234, BusB=0xABCD0000. Chained ALU ADD gives BusW=0xABCD1234, Zero=0.
- XZR: RegWr=1, RW=31, BusW=0xFFFFFFFFFFFFFFFF, then RA=31 -> BusA=0 and WrCount unchanged. Same-cycle bypass with RA=31 also yields 0.
- Bypass: BYPASS=1, X3 holds 0x1111. RegWr=1, RW=3, BusW=0xAEF4, RA=RB=3 before the edge -> BusA=BusB=0xAEF4. With BYPASS=0 they read 0x1111 until the edge, then 0xAEF4.
- Reset mid-operation: load X7=0x0832FAAA, assert Resetb low between edges -> BusD (RD=7) goes 0 immediately. A RegWr=1 edge during reset leaves X7=0.
- Wrap and sweep: write Xi=i*0x0101010101010101 for i=0..30, then read back via RA, RB and RD -> all match. Force WrCount from 0xFFFF by 65536 writes -> wraps to 0x0000.
